coin_total_accumulator: RTL and testbench

- Upstream neighbour of the binary-to-BCD converter.
- Accepts classified-coin events from the detection pipeline, maps each coin type to its value in pence, and keeps a saturating running total.
- The 14-bit `total` output drives the converter's `binary` input directly; per-type coin counts are readable for the statistics display.

---
 rtl/coin_total_accumulator.sv | 126 ++++++++++++
 tb/tb_coin_total_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_total_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : coin_total_accumulator
// Description : Maps classified-coin events to pence, keeps a saturating
//               running total for the BCD converter, and counts coins by type.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_total_accumulator #(
    parameter int MAX_TOTAL = 9999,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [2:0]       coin_type,
    output logic             coin_ready,
    input  logic             clear,
    input  logic [2:0]       count_sel,
    output logic [13:0]      total,
    output logic             total_upd,
    output logic             saturated,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOOKUP = 2'd1;
    localparam logic [1:0] c_ST_ADD    = 2'd2;
    localparam logic [1:0] c_ST_CLEAR  = 2'd3;

    localparam logic [14:0]      c_MAX_SUM   = 15'(MAX_TOTAL);
    localparam logic [13:0]      c_MAX_TOTAL = 14'(MAX_TOTAL);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [2:0]       r_type;
    logic [7:0]       r_value;
    logic [13:0]      r_total;
    logic             r_upd;
    logic             r_sat;
    logic [CNT_W-1:0] r_cnt [0:7];

    logic [7:0]       w_value;
    logic [14:0]      w_sum;

    // Fixed coin-code to pence table
    always_comb begin
        w_value = 8'd0;
        case (r_type)
            3'd0:    w_value = 8'd1;
            3'd1:    w_value = 8'd2;
            3'd2:    w_value = 8'd5;
            3'd3:    w_value = 8'd10;
            3'd4:    w_value = 8'd20;
            3'd5:    w_value = 8'd50;
            3'd6:    w_value = 8'd100;
            default: w_value = 8'd200;
        endcase
    end

    // One extra bit so the comparison against the ceiling never overflows
    assign w_sum = {1'b0, r_total} + {7'd0, r_value};

    // Ready only when idle, out of reset and not being cleared
    assign coin_ready = rst_n & ~clear & (r_state == c_ST_IDLE);

    assign total     = r_total;
    assign total_upd = r_upd;
    assign saturated = r_sat;
    assign count_out = r_cnt[count_sel];

    // Control FSM, total and per-type counters; clear overrides any in-flight coin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_type  <= 3'd0;
            r_value <= 8'd0;
            r_total <= 14'd0;
            r_upd   <= 1'b0;
            r_sat   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clear) begin
            r_state <= c_ST_CLEAR;
            r_total <= 14'd0;
            r_upd   <= 1'b1;
            r_sat   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (coin_valid) begin
                        r_type  <= coin_type;
                        r_state <= c_ST_LOOKUP;
                    end
                end
                c_ST_LOOKUP: begin
                    r_value <= w_value;
                    r_state <= c_ST_ADD;
                end
                c_ST_ADD: begin
                    if (w_sum > c_MAX_SUM) begin
                        r_total <= c_MAX_TOTAL;
                        r_sat   <= 1'b1;
                    end else begin
                        r_total <= w_sum[13:0];
                    end
                    if (r_cnt[r_type] != c_CNT_MAX) begin
                        r_cnt[r_type] <= r_cnt[r_type] + c_CNT_ONE;
                    end
                    r_upd   <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_total_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_total_accumulator
// Description : Directed self-checking bench for coin_total_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_total_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coin_valid;
    logic [2:0]  coin_type;
    logic        coin_ready;
    logic        clear;
    logic [2:0]  count_sel;
    logic [13:0] total;
    logic        total_upd;
    logic        saturated;
    logic [7:0]  count_out;

    // Narrow-counter instance
    logic        b_valid;
    logic [2:0]  b_type;
    logic        b_ready;
    logic        b_clear;
    logic [2:0]  b_sel;
    logic [13:0] b_total;
    logic        b_upd;
    logic        b_sat;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    int upd_base;

    always #5 clk = ~clk;

    coin_total_accumulator u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .coin_ready (coin_ready),
        .clear      (clear),
        .count_sel  (count_sel),
        .total      (total),
        .total_upd  (total_upd),
        .saturated  (saturated),
        .count_out  (count_out)
    );

    coin_total_accumulator #(.MAX_TOTAL(9999), .CNT_W(2)) u_dut_narrow (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_valid (b_valid),
        .coin_type  (b_type),
        .coin_ready (b_ready),
        .clear      (b_clear),
        .count_sel  (b_sel),
        .total      (b_total),
        .total_upd  (b_upd),
        .saturated  (b_sat),
        .count_out  (b_count)
    );

    // Count update pulses away from the active edge
    always @(negedge clk) begin
        if (total_upd === 1'b1) upd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (coin_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("ready_timeout", {31'd0, coin_ready}, 32'd1);
    endtask

    // Presents a coin (coin_valid left high), checks the 3-cycle transaction
    task automatic send_coin(input logic [2:0] t, input int exp_total, input logic exp_sat);
        coin_valid = 1'b1;
        coin_type  = t;
        wait_ready();
        tick();                                   // E0: accepted
        check_eq("ready_low_e0", {31'd0, coin_ready}, 32'd0);
        tick();                                   // E1
        check_eq("upd_low_e1", {31'd0, total_upd}, 32'd0);
        tick();                                   // E2: result visible
        check_eq("upd_e2", {31'd0, total_upd}, 32'd1);
        check_eq("total_e2", {18'd0, total}, exp_total);
        check_eq("sat_e2", {31'd0, saturated}, {31'd0, exp_sat});
        check_eq("ready_e2", {31'd0, coin_ready}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 3'd0;
        clear      = 1'b0;
        count_sel  = 3'd0;
        b_valid    = 1'b0;
        b_type     = 3'd0;
        b_clear    = 1'b0;
        b_sel      = 3'd1;

        // Reset then idle
        tick();
        tick();
        check_eq("ready_in_reset", {31'd0, coin_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_total", {18'd0, total}, 32'd0);
        check_eq("rst_sat", {31'd0, saturated}, 32'd0);
        check_eq("rst_upd", {31'd0, total_upd}, 32'd0);
        check_eq("rst_ready", {31'd0, coin_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            count_sel = 3'(i);
            #1;
            check_eq("rst_count", {24'd0, count_out}, 32'd0);
        end

        // Back-to-back 10p, 2 pounds, 5p, 1p with coin_valid held
        upd_base = upd_cnt;
        send_coin(3'd3, 10, 1'b0);
        send_coin(3'd7, 210, 1'b0);
        send_coin(3'd2, 215, 1'b0);
        send_coin(3'd0, 216, 1'b0);
        coin_valid = 1'b0;
        tick();
        check_eq("seq_upd_pulses", upd_cnt - upd_base, 32'd4);
        for (int i = 0; i < 8; i++) begin
            count_sel = 3'(i);
            #1;
            check_eq("seq_count", {24'd0, count_out},
                     (i == 0 || i == 2 || i == 3 || i == 7) ? 32'd1 : 32'd0);
        end

        // Clear, then build the total up to 9899 (49 x 200 + 50+20+20+5+2+2)
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_total", {18'd0, total}, 32'd0);
        check_eq("clr_upd", {31'd0, total_upd}, 32'd1);
        for (int i = 1; i <= 49; i++) send_coin(3'd7, i * 200, 1'b0);
        send_coin(3'd5, 9850, 1'b0);
        send_coin(3'd4, 9870, 1'b0);
        send_coin(3'd4, 9890, 1'b0);
        send_coin(3'd2, 9895, 1'b0);
        send_coin(3'd1, 9897, 1'b0);
        send_coin(3'd1, 9899, 1'b0);
        // Landing exactly on the ceiling is not saturation
        send_coin(3'd6, 9999, 1'b0);
        // Overflowing clamps and sets the sticky flag
        send_coin(3'd0, 9999, 1'b1);
        send_coin(3'd7, 9999, 1'b1);
        coin_valid = 1'b0;
        count_sel  = 3'd0;
        #1;
        check_eq("sat_count0", {24'd0, count_out}, 32'd1);
        count_sel = 3'd7;
        #1;
        check_eq("sat_count7", {24'd0, count_out}, 32'd50);

        // Clear mid-coin: total 50, accept 1 pound, clear in LOOKUP
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr2_sat", {31'd0, saturated}, 32'd0);
        send_coin(3'd5, 50, 1'b0);
        coin_type = 3'd6;
        wait_ready();
        tick();                                   // accepted, now in LOOKUP
        coin_valid = 1'b0;
        clear      = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("abort_total", {18'd0, total}, 32'd0);
        check_eq("abort_upd", {31'd0, total_upd}, 32'd1);
        check_eq("abort_sat", {31'd0, saturated}, 32'd0);
        upd_base = upd_cnt;
        tick();
        tick();
        tick();
        check_eq("abort_one_pulse", upd_cnt - upd_base, 32'd1);
        check_eq("abort_total_late", {18'd0, total}, 32'd0);
        for (int i = 5; i < 7; i++) begin
            count_sel = 3'(i);
            #1;
            check_eq("abort_count", {24'd0, count_out}, 32'd0);
        end

        // Simultaneous clear and coin_valid in IDLE
        clear      = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 3'd4;
        #1;
        check_eq("simul_ready", {31'd0, coin_ready}, 32'd0);
        tick();
        clear = 1'b0;
        check_eq("simul_total", {18'd0, total}, 32'd0);
        check_eq("simul_ready_clr", {31'd0, coin_ready}, 32'd0);
        send_coin(3'd4, 20, 1'b0);
        coin_valid = 1'b0;
        count_sel  = 3'd4;
        #1;
        check_eq("simul_count4", {24'd0, count_out}, 32'd1);

        // Narrow counters: four 2p coins saturate counter at 3
        b_valid = 1'b1;
        b_type  = 3'd1;
        repeat (12) tick();
        b_valid = 1'b0;
        check_eq("narrow_total", {18'd0, b_total}, 32'd8);
        check_eq("narrow_count", {30'd0, b_count}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
